// File: rtl/miter_pkg.sv
// miter_pkg: shared state encoding, default counter width and saturating increment for the miter checker
package miter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, FAIL = 2'd3} state_e;
  localparam int CNT_W_DEF = 16;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v == max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/miter_chan_cmp.sv
// miter_chan_cmp: one channel masked compare; mism_o = any cared bit differs between gold_i and gate_i
module miter_chan_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] gold_i,
  input  logic [W-1:0] gate_i,
  input  logic [W-1:0] care_i,
  output logic         mism_o
);
  assign mism_o = |((gold_i ^ gate_i) & care_i);
endmodule

// File: rtl/miter_seq_cmp.sv
// miter_seq_cmp: gold-vs-gate miter (clk/rst, arm/clear/valid, care/gold/gate in; state/pass/fail/counters/first-fail out; MITER_SNAPSHOT_EN adds snap_gold_o/snap_gate_o)
module miter_seq_cmp
  import miter_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int W            = 8,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int SETTLE_CYC   = 2,
  parameter int MIN_SAMPLES  = 1,
  parameter int STOP_ON_FAIL = 1,
  localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_i,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [NCH*W-1:0]   care_i,
  input  logic [NCH*W-1:0]   gold_i,
  input  logic [NCH*W-1:0]   gate_i,
  output logic [1:0]         state_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [NCH-1:0]     fail_ch_o,
  output logic [CNT_W-1:0]   mism_cnt_o,
  output logic [CNT_W-1:0]   samp_cnt_o,
  output logic [CH_W-1:0]    first_ch_o,
`ifdef MITER_SNAPSHOT_EN
  output logic [W-1:0]       snap_gold_o,
  output logic [W-1:0]       snap_gate_o,
`endif
  output logic [CNT_W-1:0]   first_stamp_o
);
  localparam int SW = $clog2(SETTLE_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] samp_q, samp_d, mism_cnt_q, mism_cnt_d, stamp_q, stamp_d;
  logic [NCH-1:0] fail_ch_q, fail_ch_d, mism;
  logic [CH_W-1:0] first_ch_q, first_ch_d, lo;
  logic cmp;
`ifdef MITER_SNAPSHOT_EN
  logic [W-1:0] snap_gold_q, snap_gold_d, snap_gate_q, snap_gate_d;
`endif
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    miter_chan_cmp #(.W(W)) u_cmp (
      .gold_i(gold_i[c*W +: W]),
      .gate_i(gate_i[c*W +: W]),
      .care_i(care_i[c*W +: W]),
      .mism_o(mism[c])
    );
  end
  // descending scan leaves the lowest mismatching channel in lo
  always_comb begin
    lo = '0;
    for (int i = NCH - 1; i >= 0; i--) if (mism[i]) lo = CH_W'(i);
  end
  // FAIL keeps comparing only when the run is not frozen on first fail
  assign cmp = valid_i && (state_q == CHECK || (state_q == FAIL && STOP_ON_FAIL == 0));
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    samp_d     = samp_q;
    mism_cnt_d = mism_cnt_q;
    stamp_d    = stamp_q;
    fail_ch_d  = fail_ch_q;
    first_ch_d = first_ch_q;
`ifdef MITER_SNAPSHOT_EN
    snap_gold_d = snap_gold_q;
    snap_gate_d = snap_gate_q;
`endif
    if (clear_i) begin
      state_d    = IDLE;
      settle_d   = '0;
      samp_d     = '0;
      mism_cnt_d = '0;
      stamp_d    = '0;
      fail_ch_d  = '0;
      first_ch_d = '0;
`ifdef MITER_SNAPSHOT_EN
      snap_gold_d = '0;
      snap_gate_d = '0;
`endif
    end else begin
      if (state_q == IDLE && arm_i) begin
        state_d  = (SETTLE_CYC == 0) ? CHECK : SETTLE;
        settle_d = '0;
      end
      if (state_q == SETTLE && valid_i) begin
        settle_d = settle_q + 1'b1;
        state_d  = (settle_q + 1'b1 == SW'(SETTLE_CYC)) ? CHECK : SETTLE;
      end
      if (cmp) begin
        samp_d    = CNT_W'(sat_inc(64'(samp_q), 64'(CNT_MAX)));
        fail_ch_d = fail_ch_q | mism;
        if (|mism) mism_cnt_d = CNT_W'(sat_inc(64'(mism_cnt_q), 64'(CNT_MAX)));
        // first-fail capture happens only on the CHECK->FAIL sample, so once per run
        if (|mism && state_q == CHECK) begin
          state_d    = FAIL;
          first_ch_d = lo;
          stamp_d    = samp_q;
`ifdef MITER_SNAPSHOT_EN
          snap_gold_d = gold_i[int'(lo)*W +: W];
          snap_gate_d = gate_i[int'(lo)*W +: W];
`endif
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      samp_q     <= '0;
      mism_cnt_q <= '0;
      stamp_q    <= '0;
      fail_ch_q  <= '0;
      first_ch_q <= '0;
`ifdef MITER_SNAPSHOT_EN
      snap_gold_q <= '0;
      snap_gate_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      samp_q     <= samp_d;
      mism_cnt_q <= mism_cnt_d;
      stamp_q    <= stamp_d;
      fail_ch_q  <= fail_ch_d;
      first_ch_q <= first_ch_d;
`ifdef MITER_SNAPSHOT_EN
      snap_gold_q <= snap_gold_d;
      snap_gate_q <= snap_gate_d;
`endif
    end
  end
  assign state_o       = state_q;
  assign pass_o        = state_q == CHECK && samp_q >= CNT_W'(MIN_SAMPLES) && fail_ch_q == '0;
  assign fail_o        = |fail_ch_q;
  assign fail_ch_o     = fail_ch_q;
  assign mism_cnt_o    = mism_cnt_q;
  assign samp_cnt_o    = samp_q;
  assign first_ch_o    = first_ch_q;
  assign first_stamp_o = stamp_q;
`ifdef MITER_SNAPSHOT_EN
  assign snap_gold_o = snap_gold_q;
  assign snap_gate_o = snap_gate_q;
`endif
endmodule

// File: tb/tb_miter_seq_cmp.sv
// tb_miter_seq_cmp: random and directed checks of two miter_seq_cmp configurations against a behavioural model
module tb_miter_seq_cmp;
  logic clk = 0, rst = 1, arm = 0, clr = 0, valid = 0;
  logic [31:0] care = 0, gold = 0, gate = 0;
  logic [1:0] st, st_s, fc, fc_s;
  logic pass, pass_s, fail, fail_s;
  logic [3:0] fch, fch_s, mc_s, sc_s, stamp_s;
  logic [15:0] mc, sc, stamp;
`ifdef MITER_SNAPSHOT_EN
  logic [7:0] sg, sgt, sg_s, sgt_s;
`endif
  always #5 clk = ~clk;
  miter_seq_cmp u_dut (
    .clk(clk), .rst(rst), .arm_i(arm), .clear_i(clr), .valid_i(valid),
    .care_i(care), .gold_i(gold), .gate_i(gate),
    .state_o(st), .pass_o(pass), .fail_o(fail), .fail_ch_o(fch),
    .mism_cnt_o(mc), .samp_cnt_o(sc), .first_ch_o(fc),
`ifdef MITER_SNAPSHOT_EN
    .snap_gold_o(sg), .snap_gate_o(sgt),
`endif
    .first_stamp_o(stamp)
  );
  miter_seq_cmp #(.CNT_W(4), .STOP_ON_FAIL(0)) u_sat (
    .clk(clk), .rst(rst), .arm_i(arm), .clear_i(clr), .valid_i(valid),
    .care_i(care), .gold_i(gold), .gate_i(gate),
    .state_o(st_s), .pass_o(pass_s), .fail_o(fail_s), .fail_ch_o(fch_s),
    .mism_cnt_o(mc_s), .samp_cnt_o(sc_s), .first_ch_o(fc_s),
`ifdef MITER_SNAPSHOT_EN
    .snap_gold_o(sg_s), .snap_gate_o(sgt_s),
`endif
    .first_stamp_o(stamp_s)
  );
  typedef struct {int st; int settle; int samp; int mism; int fch; int fc; int stamp; int sg; int sgt;} mdl_t;
  mdl_t m, ms;
  int n_cmp = 0, n_err = 0;
  // one clock of the checker's rules: st 0=IDLE 1=SETTLE 2=CHECK 3=FAIL, two settle samples
  function automatic mdl_t mstep(mdl_t x, int stop, int cmax);
    int s0 = x.st;
    int bits = 0;
    if (clr) begin
      x = '{default: 0};
      return x;
    end
    for (int c = 0; c < 4; c++) if (((((gold ^ gate) & care) >> (8 * c)) & 32'hFF) != 0) bits |= 1 << c;
    if (s0 == 0 && arm) begin
      x.st = 1;
      x.settle = 0;
    end
    if (s0 == 1 && valid) begin
      x.settle++;
      if (x.settle == 2) x.st = 2;
    end
    if (valid && (s0 == 2 || (s0 == 3 && stop == 0))) begin
      if (bits != 0 && s0 == 2) begin
        x.st = 3;
        x.stamp = x.samp;
        for (int c = 3; c >= 0; c--) if ((bits >> c) & 1) x.fc = c;
        x.sg = int'((gold >> (8 * x.fc)) & 32'hFF);
        x.sgt = int'((gate >> (8 * x.fc)) & 32'hFF);
      end
      x.samp = (x.samp < cmax) ? x.samp + 1 : cmax;
      if (bits != 0) x.mism = (x.mism < cmax) ? x.mism + 1 : cmax;
      x.fch |= bits;
    end
    return x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("state", 32'(st), m.st);
    chk("pass", 32'(pass), 32'(m.st == 2 && m.samp >= 1 && m.fch == 0));
    chk("fail", 32'(fail), 32'(m.fch != 0));
    chk("fail_ch", 32'(fch), m.fch);
    chk("mism_cnt", 32'(mc), m.mism);
    chk("samp_cnt", 32'(sc), m.samp);
    chk("first_ch", 32'(fc), m.fc);
    chk("first_stamp", 32'(stamp), m.stamp);
    chk("sat_state", 32'(st_s), ms.st);
    chk("sat_fail_ch", 32'(fch_s), ms.fch);
    chk("sat_mism_cnt", 32'(mc_s), ms.mism);
    chk("sat_samp_cnt", 32'(sc_s), ms.samp);
    chk("sat_first_stamp", 32'(stamp_s), ms.stamp);
`ifdef MITER_SNAPSHOT_EN
    chk("snap_gold", 32'(sg), m.sg);
    chk("snap_gate", 32'(sgt), m.sgt);
`endif
  endtask
  task automatic drive(input bit a, input bit c, input bit v, input logic [31:0] g, input logic [31:0] t, input logic [31:0] k);
    arm = a; clr = c; valid = v; gold = g; gate = t; care = k;
    @(posedge clk);
    m = mstep(m, 1, 65535);
    ms = mstep(ms, 0, 15);
    #1;
    chk_all();
  endtask
  task automatic same(input int n);
    logic [31:0] g;
    for (int i = 0; i < n; i++) begin
      g = $urandom;
      drive(0, 0, 1, g, g, $urandom);
    end
  endtask
  task automatic rearm();
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] g, t;
    m = '{default: 0};
    ms = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 0;
    drive(1, 0, 0, 0, 0, 0);
    same(10);
    chk("t1_state", 32'(st), 2);
    chk("t1_samp", 32'(sc), 8);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail", 32'(fail), 0);
    rearm();
    same(6);
    g = $urandom; g[23:16] = 8'h5A; t = g; t[23:16] = 8'h5B;
    drive(0, 0, 1, g, t, 32'hFFFF_FFFF);
    chk("t2_state", 32'(st), 3);
    chk("t2_fail_ch", 32'(fch), 4'b0100);
    chk("t2_first_ch", 32'(fc), 2);
    chk("t2_stamp", 32'(stamp), 4);
    for (int i = 0; i < 3; i++) begin
      g = $urandom;
      drive(0, 0, 1, g, ~g, 32'hFFFF_FFFF);
    end
    chk("t2_frozen", 32'(mc), 1);
    drive(1, 1, 0, 0, 0, 0);
    chk("t6_state", 32'(st), 0);
    chk("t6_samp", 32'(sc), 0);
    chk("t6_mism", 32'(mc), 0);
    drive(1, 0, 0, 0, 0, 0);
    same(5);
    g = $urandom; g[23:16] = 8'h5A; t = g; t[23:16] = 8'h5B;
    drive(0, 0, 1, g, t, 32'hFFFE_FFFF);
    chk("t3_fail", 32'(fail), 0);
    chk("t3_pass", 32'(pass), 1);
    g = $urandom;
    drive(0, 0, 1, g, g ^ 32'h0100_0100, 32'hFFFF_FFFF);
    chk("t4_first_ch", 32'(fc), 1);
    chk("t4_fail_ch", 32'(fch), 4'b1010);
    for (int i = 0; i < 3; i++) begin
      g = $urandom;
      drive(0, 0, 1, g, g ^ 32'h1, 32'hFFFF_FFFF);
    end
    chk("t4_frozen", 32'(mc), 1);
    rearm();
    same(2);
    for (int i = 0; i < 20; i++) begin
      g = $urandom;
      drive(0, 0, 1, g, g ^ 32'h1, 32'hFFFF_FFFF);
    end
    chk("t5_sat_mism", 32'(mc_s), 15);
    chk("t5_sat_samp", 32'(sc_s), 15);
    for (int r = 0; r < 4; r++) begin
      rearm();
      for (int i = 0; i < 40; i++) begin
        g = $urandom;
        t = ($urandom_range(0, 99) < 6) ? g ^ (32'h1 << $urandom_range(0, 31)) : g;
        drive($urandom_range(0, 7) == 0, 0, $urandom_range(0, 3) != 0, g, t, $urandom);
      end
    end
    rearm();
    same(5);
    #2;
    rst = 1;
    #1;
    m = '{default: 0};
    ms = '{default: 0};
    chk_all();
    chk("t7_state", 32'(st), 0);
    chk("t7_samp", 32'(sc), 0);
    @(negedge clk);
    rst = 0;
    drive(1, 0, 0, 0, 0, 0);
    same(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
